// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// alu_share_arbiter_if: requester handshakes and shared-ALU bus | rev 1.0
// ------------------------------------------------------------------------
interface alu_share_arbiter_if #(
   parameter int IO_BUS_WIDTH  = 32,
   parameter int CTR_BUS_WIDTH = 4
);
   logic                     i_r0_valid;
   logic                     o_r0_ready;
   logic [CTR_BUS_WIDTH-1:0] i_r0_ctr_code;
   logic [IO_BUS_WIDTH-1:0]  i_r0_data_a;
   logic [IO_BUS_WIDTH-1:0]  i_r0_data_b;
   logic                     o_r0_result_valid;
   logic                     i_r0_result_ready;
   logic [IO_BUS_WIDTH-1:0]  o_r0_result;

   logic                     i_r1_valid;
   logic                     o_r1_ready;
   logic [CTR_BUS_WIDTH-1:0] i_r1_ctr_code;
   logic [IO_BUS_WIDTH-1:0]  i_r1_data_a;
   logic [IO_BUS_WIDTH-1:0]  i_r1_data_b;
   logic                     o_r1_result_valid;
   logic                     i_r1_result_ready;
   logic [IO_BUS_WIDTH-1:0]  o_r1_result;

   logic [CTR_BUS_WIDTH-1:0] o_alu_ctr_code;
   logic [IO_BUS_WIDTH-1:0]  o_alu_data_a;
   logic [IO_BUS_WIDTH-1:0]  o_alu_data_b;
   logic [IO_BUS_WIDTH-1:0]  i_alu_data;

   modport slave (
      input  i_r0_valid, i_r0_ctr_code, i_r0_data_a, i_r0_data_b, i_r0_result_ready,
      output o_r0_ready, o_r0_result_valid, o_r0_result,
      input  i_r1_valid, i_r1_ctr_code, i_r1_data_a, i_r1_data_b, i_r1_result_ready,
      output o_r1_ready, o_r1_result_valid, o_r1_result,
      output o_alu_ctr_code, o_alu_data_a, o_alu_data_b,
      input  i_alu_data
   );

   modport master (
      output i_r0_valid, i_r0_ctr_code, i_r0_data_a, i_r0_data_b, i_r0_result_ready,
      input  o_r0_ready, o_r0_result_valid, o_r0_result,
      output i_r1_valid, i_r1_ctr_code, i_r1_data_a, i_r1_data_b, i_r1_result_ready,
      input  o_r1_ready, o_r1_result_valid, o_r1_result,
      input  o_alu_ctr_code, o_alu_data_a, o_alu_data_b,
      output i_alu_data
   );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------------
// alu_share_arbiter: round-robin time-sharing of one ALU by r0/r1 | rev 1.0
// ------------------------------------------------------------------------
module alu_share_arbiter #(
   parameter int IO_BUS_WIDTH  = 32,
   parameter int CTR_BUS_WIDTH = 4
) (
   input  wire logic          i_clk,
   input  wire logic          i_reset,
   alu_share_arbiter_if.slave bus
);
   localparam logic [CTR_BUS_WIDTH-1:0] c_ALU_NOP = {CTR_BUS_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic                     owner_q, owner_d;
   logic                     last_grant_q, last_grant_d;
   logic [CTR_BUS_WIDTH-1:0] op_code_q, op_code_d;
   logic [IO_BUS_WIDTH-1:0]  op_a_q, op_a_d;
   logic [IO_BUS_WIDTH-1:0]  op_b_q, op_b_d;
   logic [IO_BUS_WIDTH-1:0]  res0_q, res0_d;
   logic [IO_BUS_WIDTH-1:0]  res1_q, res1_d;
   logic                     w_grant0, w_grant1;

   // On a tie the requester that did not win last time is granted.
   assign w_grant0 = bus.i_r0_valid && (!bus.i_r1_valid ||  last_grant_q);
   assign w_grant1 = bus.i_r1_valid && (!bus.i_r0_valid || !last_grant_q);

   always_comb begin
      state_d                = state_q;
      owner_d                = owner_q;
      last_grant_d           = last_grant_q;
      op_code_d              = op_code_q;
      op_a_d                 = op_a_q;
      op_b_d                 = op_b_q;
      res0_d                 = res0_q;
      res1_d                 = res1_q;
      bus.o_r0_ready         = 1'b0;
      bus.o_r1_ready         = 1'b0;
      bus.o_r0_result_valid  = 1'b0;
      bus.o_r1_result_valid  = 1'b0;
      bus.o_alu_ctr_code     = c_ALU_NOP;

      case (state_q)
         S_IDLE: begin
            bus.o_r0_ready = w_grant0 && !i_reset;
            bus.o_r1_ready = w_grant1 && !i_reset;
            if (w_grant0 || w_grant1) begin
               owner_d      = w_grant1;
               last_grant_d = w_grant1;
               op_code_d    = w_grant1 ? bus.i_r1_ctr_code : bus.i_r0_ctr_code;
               op_a_d       = w_grant1 ? bus.i_r1_data_a   : bus.i_r0_data_a;
               op_b_d       = w_grant1 ? bus.i_r1_data_b   : bus.i_r0_data_b;
               state_d      = S_EXEC;
            end
         end
         S_EXEC: begin
            bus.o_alu_ctr_code = op_code_q;
            if (owner_q) res1_d = bus.i_alu_data;
            else         res0_d = bus.i_alu_data;
            state_d = S_RESP;
         end
         S_RESP: begin
            bus.o_r0_result_valid = !owner_q;
            bus.o_r1_result_valid =  owner_q;
            if (owner_q ? bus.i_r1_result_ready : bus.i_r0_result_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q      <= S_IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         op_code_q    <= c_ALU_NOP;
         op_a_q       <= '0;
         op_b_q       <= '0;
         res0_q       <= '0;
         res1_q       <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         op_code_q    <= op_code_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         res0_q       <= res0_d;
         res1_q       <= res1_d;
      end
   end

   assign bus.o_alu_data_a = op_a_q;
   assign bus.o_alu_data_b = op_b_q;
   assign bus.o_r0_result  = res0_q;
   assign bus.o_r1_result  = res1_q;
endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Sequencer/arbiter that time-shares one combinational ALU between two requesters (r0, r1), e.g. the EX-stage path and the debug unit.
- Arbitrates with round-robin and a valid/ready handshake.
- Registers the operands that drive the shared ALU.
- Captures the ALU result and returns it with result-side backpressure.
- Sits beside the EX stage in the pipeline and drives the ALU's control code and operand inputs.

Parameters:
IO_BUS_WIDTH, 32, operand/result width
CTR_BUS_WIDTH, 4, ALU control-code width (shared ALU code definitions)

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  synchronous, active-high reset
i_r0_valid  in  1  r0 request valid
o_r0_ready  out  1  r0 request accepted this cycle when high with valid
i_r0_ctr_code  in  CTR_BUS_WIDTH  r0 ALU operation code
i_r0_data_a  in  IO_BUS_WIDTH  r0 operand A (signed)
i_r0_data_b  in  IO_BUS_WIDTH  r0 operand B (signed)
o_r0_result_valid  out  1  r0 result available
i_r0_result_ready  in  1  r0 consumes result
o_r0_result  out  IO_BUS_WIDTH  r0 result
i_r1_* / o_r1_*  (same seven signals for r1)
o_alu_ctr_code  out  CTR_BUS_WIDTH  to shared ALU control code
o_alu_data_a  out  IO_BUS_WIDTH  to shared ALU operand A
o_alu_data_b  out  IO_BUS_WIDTH  to shared ALU operand B
i_alu_data  in  IO_BUS_WIDTH  from shared ALU result

Behaviour:
- FSM states: IDLE, EXEC, RESP. Registers: state, owner (1 bit), last_grant (1 bit), op registers (code, A, B), result register.
- Reset values:
  - state=IDLE, last_grant=1 so r0 wins the first tie.
  - All o_*_ready=0, all o_*_result_valid=0, o_*_result=0.
  - o_alu_ctr_code = NOP code; o_alu_data_a/b = 0.
- IDLE:
  - Grant logic is combinational. If only one valid, that requester is granted. If both valid, grant the requester != last_grant.
  - Granted requester's o_rN_ready=1; the other's is 0. Ready is never high outside IDLE.
  - On valid&&ready at edge t: latch code/A/B into op registers, owner=grant, last_grant=grant, state->EXEC.
  - No valid: stay IDLE, ALU code held at NOP.
- EXEC (cycle t+1):
  - Op registers drive the ALU.
  - At edge: result_reg <= i_alu_data (full width, no modification), state->RESP.
  - o_alu_ctr_code returns to NOP from the edge that leaves EXEC.
- RESP (cycle t+2 onward):
  - o_r<owner>_result_valid=1 and o_r<owner>_result=result_reg. The other requester's result_valid stays 0.
  - Hold result stable until i_r<owner>_result_ready=1; at that edge go to IDLE.
  - New requests are accepted no earlier than the following cycle.
- Latency: accept edge t -> result_valid high in cycle t+2. Max throughput: one operation per 3 cycles.
- o_rN_result keeps the last delivered value after valid drops; it is only updated on that owner's next EXEC capture.
- Requester may drop valid before acceptance; no state change results.
- Operands change after acceptance: ignored (op registers hold).
- Single requester issuing back-to-back: granted every time; no forced idle for fairness.
- i_reset mid-EXEC or mid-RESP: the operation is discarded, no result_valid is produced, and all registers return to reset values next edge.
- Reset has priority over every other event in the same cycle.

Test Plan:
- After reset, r0 requests ADD A=5, B=7 at edge t -> o_r0_ready=1 in cycle t; o_alu_ctr_code=ADD in t+1; o_r0_result_valid=1 with result=12 in t+2; r1 outputs stay 0.
- r0 SUB A=3, B=10 with result_ready held 0 for 3 cycles -> result=-7 (0xFFFFFFF9) held stable and valid for all 3 cycles; returns to IDLE one edge after result_ready=1.
- r0 AND (0xF0F0F0F0, 0x0FF00FF0) and r1 OR (0x1, 0x2) both valid from reset:
  - r0 is granted first -> 0x00F000F0.
  - r1 is granted next -> 0x3, with o_r0_ready=0 throughout.
  - Then the tie repeats with r0 winning.
- r1 issues 3 consecutive SLT ops (-1<1, 5<2, 0<0) with result_ready tied 1 -> results 1, 0, 0 at 3-cycle spacing; r0 never asserts result_valid.
- i_reset asserted in EXEC of r0 XOR -> next cycle state=IDLE, result_valid=0, o_alu_ctr_code=NOP; no result is ever delivered for that op.
- Idle with no valid for 5 cycles -> o_alu_ctr_code=NOP every cycle, all readys 0, all result_valid 0.
